// File: rtl/layer1_input_scheduler_pkg.sv
// Shared constants and FSM state encoding for the Layer 1 input scheduler.
package layer1_input_scheduler_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam int NUM_PIXELS  = 784;
    localparam int PIXEL_WIDTH = 8;
    localparam int QUEUE_DEPTH = 1024;
    localparam int INDEX_WIDTH = 10;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_RELEASE = 2'd2
    } sched_state_e;

endpackage

// File: rtl/layer1_input_scheduler_index_fifo.sv
// Index FIFO: synchronous push/pop, show-ahead head, occupancy count.
module index_fifo
    import layer1_input_scheduler_pkg::*;
#(
    parameter int DEPTH = QUEUE_DEPTH,
    parameter int WIDTH = INDEX_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    if ((DEPTH & (DEPTH - 1)) != 0) begin : g_depth_pow2_check
        $fatal(1, "index_fifo: DEPTH must be a power of two");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_pop;

    assign empty  = (count_q == '0);
    assign do_pop = pop & ~empty;
    assign count  = count_q;
    // Head is read combinationally so the consumer sees it without a read cycle;
    // forced to zero while empty so nothing stale leaks out after a flush.
    assign head   = empty ? '0 : mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/layer1_input_scheduler.sv
// Layer 1 input scheduler: queues active pixel indices, then hands the queue to Layer 1.
// Optional build macro SCHED_THRESHOLD_EN selects threshold-based activation.
module layer1_input_scheduler
    import layer1_input_scheduler_pkg::*;
#(
    parameter int NUM_PIX   = NUM_PIXELS,
    parameter int PIX_W     = PIXEL_WIDTH,
    parameter int Q_DEPTH   = QUEUE_DEPTH,
    parameter int IDX_W     = INDEX_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pixelValid,
    input  logic [PIX_W-1:0] pixelIn,
    input  logic             pixelLast,
    output logic             pixelReady,
    input  logic [PIX_W-1:0] thresholdIn,
    output logic             inputsReady,
    output logic             queueEmpty,
    output logic [IDX_W-1:0] queueOut,
    input  logic             dequeue,
    output logic             emptyImage,
    output logic             frameError
);
    if (Q_DEPTH < NUM_PIX) begin : g_depth_check
        $fatal(1, "layer1_input_scheduler: queue cannot hold a full image");
    end

    localparam logic [IDX_W-1:0] LAST_INDEX = IDX_W'(NUM_PIX - 1);

    sched_state_e          state_q, state_d;
    logic [IDX_W-1:0]      index_q, index_d;
    logic                  inputs_ready_q, inputs_ready_d;
    logic                  empty_image_q, empty_image_d;
    logic                  frame_error_q, frame_error_d;
    logic                  pixel_accept, pixel_active, at_last_index, closing;
    logic                  fifo_push, fifo_pop, fifo_empty;
    logic [$clog2(Q_DEPTH):0] fifo_count;

`ifdef SCHED_THRESHOLD_EN
    logic [PIX_W-1:0] thr_q, thr_d;
    // The first pixel compares against the live input; later pixels use the captured value.
    assign thr_d        = (pixel_accept && index_q == '0) ? thresholdIn : thr_q;
    assign pixel_active = pixelIn > ((index_q == '0) ? thresholdIn : thr_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            thr_q <= '0;
        end else begin
            thr_q <= thr_d;
        end
    end
`else
    logic unused_threshold;
    assign unused_threshold = ^thresholdIn;
    assign pixel_active     = (pixelIn != '0);
`endif

    assign pixelReady    = (state_q == ST_LOAD) & ~reset;
    assign pixel_accept  = pixelValid & pixelReady;
    assign at_last_index = (index_q == LAST_INDEX);
    assign closing       = pixelLast | at_last_index;

    always_comb begin
        state_d        = state_q;
        index_d        = index_q;
        inputs_ready_d = inputs_ready_q;
        empty_image_d  = FALSE;
        frame_error_d  = frame_error_q;
        fifo_push      = FALSE;
        fifo_pop       = FALSE;
        case (state_q)
            ST_LOAD: begin
                if (pixel_accept) begin
                    fifo_push = pixel_active;
                    index_d   = index_q + IDX_W'(1);
                    if (closing) begin
                        index_d = '0;
                        if (pixelLast != at_last_index) begin
                            frame_error_d = TRUE;
                        end
                        // No pops happen in LOAD, so the pre-push count decides emptiness.
                        if (fifo_count == '0 && !pixel_active) begin
                            empty_image_d = TRUE;
                        end else begin
                            state_d        = ST_PRESENT;
                            inputs_ready_d = TRUE;
                        end
                    end
                end
            end
            ST_PRESENT: begin
                if (fifo_empty) begin
                    state_d = ST_RELEASE;
                end else begin
                    fifo_pop = dequeue;
                end
            end
            ST_RELEASE: begin
                state_d        = ST_LOAD;
                inputs_ready_d = FALSE;
            end
            default: begin
                state_d        = ST_LOAD;
                inputs_ready_d = FALSE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_LOAD;
            index_q        <= '0;
            inputs_ready_q <= FALSE;
            empty_image_q  <= FALSE;
            frame_error_q  <= FALSE;
        end else begin
            state_q        <= state_d;
            index_q        <= index_d;
            inputs_ready_q <= inputs_ready_d;
            empty_image_q  <= empty_image_d;
            frame_error_q  <= frame_error_d;
        end
    end

    index_fifo #(
        .DEPTH (Q_DEPTH),
        .WIDTH (IDX_W)
    ) u_index_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (index_q),
        .pop       (fifo_pop),
        .head      (queueOut),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign queueEmpty  = fifo_empty;
    assign inputsReady = inputs_ready_q;
    assign emptyImage  = empty_image_q;
    assign frameError  = frame_error_q;

endmodule

// File: tb/tb_layer1_input_scheduler.sv
// Directed bench for layer1_input_scheduler; covers both SCHED_THRESHOLD_EN builds.
module tb_layer1_input_scheduler;
    import layer1_input_scheduler_pkg::*;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   pixelValid;
    logic [PIXEL_WIDTH-1:0] pixelIn;
    logic                   pixelLast;
    logic                   pixelReady;
    logic [PIXEL_WIDTH-1:0] thresholdIn;
    logic                   inputsReady;
    logic                   queueEmpty;
    logic [INDEX_WIDTH-1:0] queueOut;
    logic                   dequeue;
    logic                   emptyImage;
    logic                   frameError;

    int total = 0;
    int bad   = 0;

    logic [PIXEL_WIDTH-1:0] img [NUM_PIXELS];
    logic [PIXEL_WIDTH-1:0] thr_after;
    int exp_q [$];

    always #5 clk = ~clk;

    layer1_input_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .pixelValid  (pixelValid),
        .pixelIn     (pixelIn),
        .pixelLast   (pixelLast),
        .pixelReady  (pixelReady),
        .thresholdIn (thresholdIn),
        .inputsReady (inputsReady),
        .queueEmpty  (queueEmpty),
        .queueOut    (queueOut),
        .dequeue     (dequeue),
        .emptyImage  (emptyImage),
        .frameError  (frameError)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < NUM_PIXELS; i++) img[i] = '0;
    endtask

    // Streams pixels 0..last_at; the caller's thresholdIn applies to pixel 0, thr_after afterwards.
    task automatic send_image(input int last_at, input bit last_flag);
        for (int i = 0; i <= last_at; i++) begin
            @(negedge clk);
            if (i == 0) check("pixel_ready_first", pixelReady, 1);
            if (i == 1) thresholdIn = thr_after;
            pixelValid = 1'b1;
            pixelIn    = img[i];
            pixelLast  = last_flag && (i == last_at);
        end
        @(negedge clk);
        pixelValid = 1'b0;
        pixelLast  = 1'b0;
        pixelIn    = '0;
        dequeue    = 1'b0;
        $display("image sent: %0d pixels, inputsReady=%0d frameError=%0d", last_at + 1, inputsReady, frameError);
    endtask

    task automatic drain(input bit keep_deq);
        for (int k = 0; k < exp_q.size(); k++) begin
            check("q_empty_before_pop", queueEmpty, 0);
            check("queue_out", queueOut, exp_q[k]);
            $display("pop %0d: queueOut=%0d", k, queueOut);
            dequeue = 1'b1;
            @(negedge clk);
            if (!keep_deq) dequeue = 1'b0;
        end
        check("q_empty_after_drain", queueEmpty, 1);
        check("ready_after_drain", inputsReady, 1);
        @(negedge clk);
        check("ready_in_release", inputsReady, 1);
        check("q_empty_in_release", queueEmpty, 1);
        @(negedge clk);
        check("ready_dropped", inputsReady, 0);
        check("pixel_ready_reload", pixelReady, 1);
        check("qout_zero_when_empty", queueOut, 0);
    endtask

    initial begin
        reset       = 1'b1;
        pixelValid  = 1'b0;
        pixelIn     = '0;
        pixelLast   = 1'b0;
        thresholdIn = '0;
        thr_after   = '0;
        dequeue     = 1'b0;
        clear_img();

        repeat (3) @(negedge clk);
        check("rst_pixel_ready", pixelReady, 0);
        check("rst_inputs_ready", inputsReady, 0);
        check("rst_queue_empty", queueEmpty, 1);
        check("rst_queue_out", queueOut, 0);
        check("rst_empty_image", emptyImage, 0);
        check("rst_frame_error", frameError, 0);
        reset = 1'b0;
        #1;
        check("pixel_ready_after_rst", pixelReady, 1);

        // Active pixels 3, 100, 783; dequeue stays high through RELEASE into the next load.
        clear_img();
        img[3] = 8'd9; img[100] = 8'd50; img[783] = 8'd255;
        send_image(783, 1'b1);
        check("t1_inputs_ready", inputsReady, 1);
        check("t1_pixel_ready_low", pixelReady, 0);
        check("t1_frame_error", frameError, 0);
        exp_q = '{3, 100, 783};
        drain(1'b1);

        // Early pixelLast at index 500 while dequeue is still held high during loading.
        clear_img();
        img[1] = 8'd1; img[2] = 8'd2; img[499] = 8'd7; img[600] = 8'd8;
        send_image(500, 1'b1);
        check("t3_frame_error", frameError, 1);
        check("t3_inputs_ready", inputsReady, 1);
        exp_q = '{1, 2, 499};
        drain(1'b0);

        // All-zero image.
        clear_img();
        send_image(783, 1'b1);
        check("t2_empty_image_pulse", emptyImage, 1);
        check("t2_inputs_ready", inputsReady, 0);
        check("t2_pixel_ready", pixelReady, 1);
        @(negedge clk);
        check("t2_empty_image_cleared", emptyImage, 0);
        check("t2_inputs_ready_still", inputsReady, 0);
        check("t2_frame_error_sticky", frameError, 1);

        // Reset in PRESENT after two pops.
        clear_img();
        img[10] = 8'd3; img[20] = 8'd4; img[30] = 8'd5;
        send_image(783, 1'b1);
        check("t4_inputs_ready", inputsReady, 1);
        for (int k = 0; k < 2; k++) begin
            check("t4_queue_out", queueOut, (k == 0) ? 10 : 20);
            dequeue = 1'b1;
            @(negedge clk);
            dequeue = 1'b0;
        end
        check("t4_head_after_pops", queueOut, 30);
        reset = 1'b1;
        #1;
        check("t4_rst_queue_empty", queueEmpty, 1);
        check("t4_rst_inputs_ready", inputsReady, 0);
        check("t4_rst_frame_error", frameError, 0);
        check("t4_rst_pixel_ready", pixelReady, 0);
        @(negedge clk);
        reset = 1'b0;
        clear_img();
        img[5] = 8'd1; img[783] = 8'd1;
        send_image(783, 1'b1);
        check("t4_fresh_frame_error", frameError, 0);
        exp_q = '{5, 783};
        drain(1'b0);

        // Threshold build: 127/128/129 against 128, threshold changes after the first pixel.
        clear_img();
        img[0] = 8'd127; img[1] = 8'd128; img[2] = 8'd129; img[5] = 8'd100;
        thresholdIn = 8'd128;
        thr_after   = 8'd0;
        send_image(783, 1'b1);
        thresholdIn = 8'd0;
`ifdef SCHED_THRESHOLD_EN
        exp_q = '{2};
`else
        exp_q = '{0, 1, 2, 5};
`endif
        check("t6_inputs_ready", inputsReady, 1);
        drain(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
